forward: RTL
============

Name: forward

Overview:
- Sequential forward pass of an M-layer, N-wide fully connected ReLU network in Q8.8 fixed point.
- Computes the activation stack that the backward-pass block consumes. Both blocks use the same `activations`, `w` and bias packing.
- One multiply-accumulate per cycle, driven by a single FSM. Runs from `start` to a one-cycle `done` pulse.

Parameters:
- N, 4, layer width (neurons per layer, inputs per neuron)
- M, 4, number of layers

Ports:
- clk  input  1  clock
- rst  input  1  reset; active-low, synchronous
- start  input  1  begin a pass; sampled only in IDLE
- x  input  N*16  signed Q8.8 network input; element k at bits [k*16 +: 16]
- w  input  M*N*N*16  signed Q8.8 weights; W[l][i][j] at ((l*N*N + i*N + j)*16 +: 16)
- b  input  N*M*16  signed Q8.8 biases; b[l][i] at ((l*N + i)*16 +: 16)
- activations  output reg  (M+1)*N*16  slot 0 = input, slot l+1 = layer l output; element at (((slot*N)+k)*16 +: 16)
- y  output  N*16  combinational copy of slot M (final layer output)
- busy  output reg  1  high from the cycle after start is accepted until done
- done  output reg  1  one-cycle completion pulse

Behaviour:
- Reset (rst low at a clk edge):
  - state <= IDLE; activations, done and busy <= 0; all counters <= 0.
  - Applies mid-pass as well: the pass is abandoned and no done is produced.
- Per-layer math, for each layer l = 0..M-1 and each row i:
  - z = b[l][i] + sum over j of W[l][i][j]*a_prev[j], where a_prev = slot l.
  - a = (z > 0) ? z : 0, written to slot l+1 element i.
  - ReLU is applied on every layer, including the last.
- Product rule: 16x16 signed product giving 32 bits; Q8.8 result = product[23:8].
  - Default: truncation wraps. Accumulator is 16-bit signed and also wraps.
- FSM states:
  - IDLE: done <= 0. If start: slot 0 <= x, layer <= 0, i <= 0, busy <= 1, go INIT_ROW. Otherwise hold.
  - INIT_ROW: acc <= b[layer][i], j <= 0, go MAC.
  - MAC: acc <= acc + q8_8(W[layer][i][j] * slot_layer[j]). If j == N-1 go STORE, else j++. Takes N cycles.
  - STORE: slot layer+1 element i <= relu(acc). If i == N-1 go NEXT_LAYER, else i++ and go INIT_ROW.
  - NEXT_LAYER: if layer == M-1 go DONE_STATE, else layer++, i <= 0, go INIT_ROW.
  - DONE_STATE: done <= 1, busy <= 0, go IDLE.
- Latency:
  - Counted from the edge that samples start to the edge that raises done: M*(N*(N+2)+1)+1 cycles.
  - Defaults give 101 cycles.
  - done is high for exactly one cycle; IDLE clears it on the following edge.
- Input stability: x is captured at start. w and b must be held stable while busy. Changing them mid-pass gives undefined results; this is not checked.
- start while busy is ignored.
- start held high continuously: a new pass begins in the cycle after done, because IDLE samples start again.
- Slots are overwritten only on their STORE cycle. Slots not yet computed keep their previous-pass values until overwritten.
- Counter widths: $clog2(N)+1 bits for i and j; $clog2(M)+1 bits for layer, so M = 1 is legal.

Optional Feature:
- Macro: FORWARD_SATURATE_EN.
- When defined:
  - The product is clamped to 0x7FFF or 0x8000 if product[31:23] is not all-equal.
  - Each accumulate is a 17-bit add clamped to [-32768, 32767].
  - The initial acc load (bias) is unchanged.
- When undefined: pure two's-complement wrap as described above. No extra logic.

Test Plan:
- Identity weights (diagonal 0x0100), zero bias, x = {0x0100, 0x0200, 0xFF00, 0x0080} -> every slot 1..4 = {0x0100, 0x0200, 0x0000, 0x0080}; y identical; done 101 cycles after start, high for 1 cycle.
- Zero weights, all biases 0x0080 -> every layer output element = 0x0080; all-negative biases 0xFF80 -> all zeros.
- Layer 0 diagonal 0x7F00, layers 1..3 identity, x = all 0x0200, bias 0:
  - Without the macro: product wraps to 0xFE00 -> y = all 0x0000.
  - With FORWARD_SATURATE_EN: y = all 0x7FFF.
- start pulsed again at cycle 20 of a pass -> ignored; busy stays high; done is still exactly 101 cycles after the first start.
- rst driven low at cycle 50 of a pass -> next edge: activations = 0, busy = 0, done = 0, state IDLE; no done pulse. A fresh start then completes normally in 101 cycles.
- start held high for 300 cycles -> done pulses at cycle 101, then every 102 cycles; busy is low for exactly one cycle between passes.

Source files
------------

// File: rtl/forward_if.sv
// forward_if: start/operand/result bundle for the forward-pass block.
// Master drives start, x, w, b; slave returns activations, y, busy, done.
interface forward_if #(
  parameter int N = 4,
  parameter int M = 4
);
  logic                      start;
  logic [N*16-1:0]           x;
  logic [M*N*N*16-1:0]       w;
  logic [N*M*16-1:0]         b;
  logic [(M+1)*N*16-1:0]     activations;
  logic [N*16-1:0]           y;
  logic                      busy;
  logic                      done;

  modport master (
    output start, x, w, b,
    input  activations, y, busy, done
  );

  modport slave (
    input  start, x, w, b,
    output activations, y, busy, done
  );
endinterface

// File: rtl/forward.sv
// forward: sequential M-layer, N-wide ReLU network forward pass in Q8.8.
// Define FORWARD_SATURATE_EN for saturating products and accumulation.
module forward #(
  parameter int N = 4,
  parameter int M = 4
) (
  input logic      clk,
  input logic      rst,
  forward_if.slave bus
);
  localparam int IW = $clog2(N) + 1;
  localparam int LW = $clog2(M) + 1;
  localparam int AW = (M + 1) * N * 16;
  localparam logic [IW-1:0] I_LAST = IW'(N - 1);
  localparam logic [LW-1:0] L_LAST = LW'(M - 1);

  typedef enum logic [2:0] {
    IDLE, INIT_ROW, MAC, STORE, NEXT_LAYER, DONE_STATE
  } state_t;

  state_t             state;
  logic [LW-1:0]      layer;
  logic [IW-1:0]      i;
  logic [IW-1:0]      j;
  logic signed [15:0] acc;
  logic signed [15:0] acc_nxt;
  logic signed [15:0] w_cur;
  logic signed [15:0] a_cur;
  logic signed [15:0] b_cur;
  logic signed [15:0] term;
  logic signed [31:0] prod;
  logic [AW-1:0]      act;
  logic               busy;
  logic               done;

  always_comb begin
    w_cur = bus.w[(int'(layer) * N * N + int'(i) * N + int'(j)) * 16 +: 16];
    a_cur = act[(int'(layer) * N + int'(j)) * 16 +: 16];
    b_cur = bus.b[(int'(layer) * N + int'(i)) * 16 +: 16];
    prod  = w_cur * a_cur;
  end

`ifdef FORWARD_SATURATE_EN
  logic signed [16:0] sum;
  logic               unused_lo;

  // Product clamps when bits above the Q8.8 window disagree.
  always_comb begin
    if (prod[31:23] == '0 || prod[31:23] == '1)
      term = prod[23:8];
    else
      term = prod[31] ? 16'sh8000 : 16'sh7fff;
    sum = {acc[15], acc} + {term[15], term};
    if (sum[16] != sum[15])
      acc_nxt = sum[16] ? 16'sh8000 : 16'sh7fff;
    else
      acc_nxt = sum[15:0];
  end

  assign unused_lo = ^prod[7:0];
`else
  logic unused_bits;

  assign term        = prod[23:8];
  assign acc_nxt     = acc + term;
  assign unused_bits = ^{prod[31:24], prod[7:0]};
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      layer <= '0;
      i     <= '0;
      j     <= '0;
      acc   <= '0;
      act   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (bus.start) begin
            act[N*16-1:0] <= bus.x;
            layer <= '0;
            i     <= '0;
            busy  <= 1'b1;
            state <= INIT_ROW;
          end
        end
        INIT_ROW: begin
          acc   <= b_cur;
          j     <= '0;
          state <= MAC;
        end
        MAC: begin
          acc <= acc_nxt;
          if (j == I_LAST)
            state <= STORE;
          else
            j <= j + 1'b1;
        end
        STORE: begin
          act[(int'(layer) * N + N + int'(i)) * 16 +: 16]
            <= acc[15] ? '0 : acc;
          if (i == I_LAST) begin
            state <= NEXT_LAYER;
          end else begin
            i     <= i + 1'b1;
            state <= INIT_ROW;
          end
        end
        NEXT_LAYER: begin
          if (layer == L_LAST) begin
            state <= DONE_STATE;
          end else begin
            layer <= layer + 1'b1;
            i     <= '0;
            state <= INIT_ROW;
          end
        end
        DONE_STATE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.activations = act;
  assign bus.y           = act[M*N*16 +: N*16];
  assign bus.busy        = busy;
  assign bus.done        = done;
endmodule
